// File: rtl/lv_fault_sched.sv
// lv_fault_sched: low-voltage die fault scheduler.
// Raw error levels are filtered by per-source persistence counters and latched
// into sticky status bits. The block presents a prioritised fault request/ID
// and raises a timed active-low interrupt. It re-triggers on newly latched
// faults and supports a software clear.
module lv_fault_sched #(
   parameter int ERR_NUM   = 14,
   parameter int FLT_CNT_W = 4,
   parameter int INT_W     = 8,
   parameter int ID_W      = $clog2(ERR_NUM)
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_sft_rst,
   input  logic [ERR_NUM-1:0]   i_err,
   input  logic [ERR_NUM-1:0]   i_err_mask,
   input  logic [FLT_CNT_W-1:0] i_flt_th,
   input  logic                 i_clr_vld,
   input  logic [ERR_NUM-1:0]   i_clr_bits,
   input  logic                 i_int_en,
   output logic [ERR_NUM-1:0]   o_err_sts,
   output logic                 o_flt_req,
   output logic [ID_W-1:0]      o_flt_id,
   output logic                 o_int_n
);

   localparam int HOLD_W = (INT_W > 1) ? $clog2(INT_W) : 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ASSERT,
      ST_WAIT
   } fsmState_t;

   logic [FLT_CNT_W-1:0] r_fltCnt [ERR_NUM];
   logic [ERR_NUM-1:0]   r_sts;
   logic [ERR_NUM-1:0]   r_rep;
   logic                 r_fltReq;
   logic [ID_W-1:0]      r_fltId;
   logic                 r_intN;
   logic [HOLD_W-1:0]    r_holdCnt;
   fsmState_t            r_state;

   logic                 w_rst;
   logic [ERR_NUM-1:0]   w_qual;
   logic [ERR_NUM-1:0]   w_clrMask;
   logic [ERR_NUM-1:0]   w_stsNxt;
   logic                 w_newFlt;
   logic [ID_W-1:0]      w_idNxt;

   assign w_rst     = ~i_rst_n | i_sft_rst;
   assign w_clrMask = i_clr_vld ? i_clr_bits : '0;
   // A simultaneous qualify overrides the clear because qual is ORed in last.
   assign w_stsNxt  = w_qual | (r_sts & ~w_clrMask);
   assign w_newFlt  = |(r_sts & ~r_rep);

   // A source qualifies once its persistence count has reached the threshold.
   always_comb begin
      w_qual = '0;
      for (int n = 0; n < ERR_NUM; n++) begin
         w_qual[n] = i_err[n] & ~i_err_mask[n] & (r_fltCnt[n] >= i_flt_th);
      end
   end

   // Fixed-priority encoder: the lowest set index wins.
   always_comb begin
      w_idNxt = '0;
      for (int n = ERR_NUM - 1; n >= 0; n--) begin
         if (w_stsNxt[n]) begin
            w_idNxt = ID_W'(n);
         end
      end
   end

   // Persistence counters restart whenever the source drops or is masked.
   always_ff @(posedge i_clk) begin
      for (int n = 0; n < ERR_NUM; n++) begin
         if (w_rst || !i_err[n] || i_err_mask[n]) begin
            r_fltCnt[n] <= '0;
         end else if (r_fltCnt[n] != '1) begin
            r_fltCnt[n] <= r_fltCnt[n] + FLT_CNT_W'(1);
         end
      end
   end

   // Sticky status and the request/ID register, all built from next-state status.
   always_ff @(posedge i_clk) begin
      if (w_rst) begin
         r_sts    <= '0;
         r_fltReq <= 1'b0;
         r_fltId  <= '0;
      end else begin
         r_sts    <= w_stsNxt;
         r_fltReq <= |w_stsNxt;
         r_fltId  <= w_idNxt;
      end
   end

   // Interrupt FSM: reported-fault tracking plus a fixed-length low pulse.
   always_ff @(posedge i_clk) begin
      if (w_rst) begin
         r_state   <= ST_IDLE;
         r_rep     <= '0;
         r_holdCnt <= '0;
         r_intN    <= 1'b1;
      end else begin
         r_rep <= r_rep & w_stsNxt;
         case (r_state)
            ST_IDLE: begin
               if (w_newFlt && i_int_en) begin
                  r_state   <= ST_ASSERT;
                  r_rep     <= (r_rep | r_sts) & w_stsNxt;
                  r_holdCnt <= '0;
                  r_intN    <= 1'b0;
               end
            end
            ST_ASSERT: begin
               if (!i_int_en || (r_holdCnt == HOLD_W'(INT_W - 1))) begin
                  r_state <= ST_WAIT;
                  r_intN  <= 1'b1;
               end else begin
                  r_holdCnt <= r_holdCnt + HOLD_W'(1);
               end
            end
            ST_WAIT: begin
               if (r_sts == '0) begin
                  r_state <= ST_IDLE;
               end else if (w_newFlt && i_int_en) begin
                  r_state   <= ST_ASSERT;
                  r_rep     <= (r_rep | r_sts) & w_stsNxt;
                  r_holdCnt <= '0;
                  r_intN    <= 1'b0;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_intN  <= 1'b1;
            end
         endcase
      end
   end

   assign o_err_sts = r_sts;
   assign o_flt_req = r_fltReq;
   assign o_flt_id  = r_fltId;
   assign o_int_n   = r_intN;

endmodule

// File: tb/tb_lv_fault_sched.sv
// tb_lv_fault_sched: scoreboard bench for lv_fault_sched.
// Each scenario task drives one cycle at a time and pushes the expected outputs.
// It then pops the entry after the clock edge and compares it with the DUT.
module tb_lv_fault_sched;

   localparam int ERR_NUM   = 14;
   localparam int FLT_CNT_W = 4;
   localparam int INT_W     = 8;
   localparam int ID_W      = 4;

   typedef struct {
      string       tag;
      logic [19:0] exp;
   } expT;

   logic                 clock = 1'b0;
   logic                 rstN;
   logic                 sftRst;
   logic [ERR_NUM-1:0]   err;
   logic [ERR_NUM-1:0]   errMask;
   logic [FLT_CNT_W-1:0] th;
   logic                 clrVld;
   logic [ERR_NUM-1:0]   clrBits;
   logic                 intEn;
   logic [ERR_NUM-1:0]   errSts;
   logic                 fltReq;
   logic [ID_W-1:0]      fltId;
   logic                 intN;
   logic [19:0]          obs;

   expT sbQ[$];
   int  checks = 0;
   int  errors = 0;

   always #5 clock = ~clock;

   assign obs = {errSts, fltReq, fltId, intN};

   lv_fault_sched #(
      .ERR_NUM  (ERR_NUM),
      .FLT_CNT_W(FLT_CNT_W),
      .INT_W    (INT_W),
      .ID_W     (ID_W)
   ) dut (
      .i_clk     (clock),
      .i_rst_n   (rstN),
      .i_sft_rst (sftRst),
      .i_err     (err),
      .i_err_mask(errMask),
      .i_flt_th  (th),
      .i_clr_vld (clrVld),
      .i_clr_bits(clrBits),
      .i_int_en  (intEn),
      .o_err_sts (errSts),
      .o_flt_req (fltReq),
      .o_flt_id  (fltId),
      .o_int_n   (intN)
   );

   // Expected output word: sticky status, request, ID, interrupt.
   function automatic logic [19:0] packExp(input logic [13:0] s, input logic [3:0] id, input logic n);
      return {s, |s, id, n};
   endfunction

   // Push the expectation for the coming edge, then advance to the sampling point.
   task automatic applyStimulus(input string tag, input logic [19:0] exp);
      expT e;
      e.tag = tag;
      e.exp = exp;
      sbQ.push_back(e);
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic test_reset();
      expT e;
      th = 4'd0;
      for (int k = 0; k <= 2; k++) begin
         rstN = (k >= 2);
         err  = (k < 2) ? 14'h3FFF : 14'h0000;
         applyStimulus("reset", packExp(14'h0, 4'd0, 1'b1));
         e = sbQ.pop_front();
         checks++;
         if (obs !== e.exp) begin
            errors++;
            $display("[TB] FAIL %s k=%0d got sts=%h req=%b id=%0d int_n=%b want sts=%h req=%b id=%0d int_n=%b",
                     e.tag, k, obs[19:6], obs[5], obs[4:1], obs[0], e.exp[19:6], e.exp[5], e.exp[4:1], e.exp[0]);
         end
      end
   endtask

   task automatic test_basic_filter();
      expT e;
      logic [13:0] s;
      th = 4'd3;
      for (int k = 0; k <= 22; k++) begin
         err     = ((k <= 3) || (k >= 16 && k <= 18)) ? 14'h0020 : 14'h0000;
         clrVld  = (k == 15);
         clrBits = (k == 15) ? 14'h0020 : 14'h0000;
         s = (k >= 3 && k <= 14) ? 14'h0020 : 14'h0000;
         applyStimulus("basic_filter", packExp(s, (s != 0) ? 4'd5 : 4'd0, (k >= 4 && k <= 11) ? 1'b0 : 1'b1));
         e = sbQ.pop_front();
         checks++;
         if (obs !== e.exp) begin
            errors++;
            $display("[TB] FAIL %s k=%0d got sts=%h req=%b id=%0d int_n=%b want sts=%h req=%b id=%0d int_n=%b",
                     e.tag, k, obs[19:6], obs[5], obs[4:1], obs[0], e.exp[19:6], e.exp[5], e.exp[4:1], e.exp[0]);
         end
      end
      clrVld = 1'b0;
   endtask

   task automatic test_filter_edges();
      expT e;
      logic [13:0] s;
      for (int k = 0; k <= 43; k++) begin
         th      = (k <= 16) ? 4'd2 : 4'd15;
         err     = ((k <= 1) || (k >= 3 && k <= 5) || (k >= 17 && k <= 32)) ? 14'h0008 : 14'h0000;
         clrVld  = (k == 15) || (k == 42);
         clrBits = clrVld ? 14'h0008 : 14'h0000;
         s = ((k >= 5 && k <= 14) || (k >= 32 && k <= 41)) ? 14'h0008 : 14'h0000;
         applyStimulus("filter_edges", packExp(s, (s != 0) ? 4'd3 : 4'd0,
                       ((k >= 6 && k <= 13) || (k >= 33 && k <= 40)) ? 1'b0 : 1'b1));
         e = sbQ.pop_front();
         checks++;
         if (obs !== e.exp) begin
            errors++;
            $display("[TB] FAIL %s k=%0d got sts=%h req=%b id=%0d int_n=%b want sts=%h req=%b id=%0d int_n=%b",
                     e.tag, k, obs[19:6], obs[5], obs[4:1], obs[0], e.exp[19:6], e.exp[5], e.exp[4:1], e.exp[0]);
         end
      end
      clrVld = 1'b0;
   endtask

   task automatic test_priority();
      expT e;
      logic [13:0] s;
      logic [3:0]  id;
      th = 4'd0;
      for (int k = 0; k <= 12; k++) begin
         err     = (k == 0) ? 14'h0204 : 14'h0000;
         clrVld  = (k == 2) || (k == 10);
         clrBits = (k == 2) ? 14'h0004 : ((k == 10) ? 14'h0200 : 14'h0000);
         s  = (k <= 1) ? 14'h0204 : ((k <= 9) ? 14'h0200 : 14'h0000);
         id = (k <= 1) ? 4'd2 : ((k <= 9) ? 4'd9 : 4'd0);
         applyStimulus("priority", packExp(s, id, (k >= 1 && k <= 8) ? 1'b0 : 1'b1));
         e = sbQ.pop_front();
         checks++;
         if (obs !== e.exp) begin
            errors++;
            $display("[TB] FAIL %s k=%0d got sts=%h req=%b id=%0d int_n=%b want sts=%h req=%b id=%0d int_n=%b",
                     e.tag, k, obs[19:6], obs[5], obs[4:1], obs[0], e.exp[19:6], e.exp[5], e.exp[4:1], e.exp[0]);
         end
      end
      clrVld = 1'b0;
   endtask

   task automatic test_clear_collision();
      expT e;
      logic [13:0] s;
      th = 4'd0;
      for (int k = 0; k <= 11; k++) begin
         err     = (k == 0) ? 14'h0010 : 14'h0000;
         clrVld  = (k == 0) || (k == 10);
         clrBits = clrVld ? 14'h0010 : 14'h0000;
         s = (k <= 9) ? 14'h0010 : 14'h0000;
         applyStimulus("clear_collision", packExp(s, (s != 0) ? 4'd4 : 4'd0, (k >= 1 && k <= 8) ? 1'b0 : 1'b1));
         e = sbQ.pop_front();
         checks++;
         if (obs !== e.exp) begin
            errors++;
            $display("[TB] FAIL %s k=%0d got sts=%h req=%b id=%0d int_n=%b want sts=%h req=%b id=%0d int_n=%b",
                     e.tag, k, obs[19:6], obs[5], obs[4:1], obs[0], e.exp[19:6], e.exp[5], e.exp[4:1], e.exp[0]);
         end
      end
      clrVld = 1'b0;
   endtask

   task automatic test_back_to_back();
      expT e;
      logic [13:0] s;
      logic [3:0]  id;
      th = 4'd0;
      for (int k = 0; k <= 20; k++) begin
         err     = (k == 0) ? 14'h0040 : ((k == 3) ? 14'h0002 : 14'h0000);
         clrVld  = (k == 19);
         clrBits = clrVld ? 14'h0042 : 14'h0000;
         s  = (k <= 2) ? 14'h0040 : ((k <= 18) ? 14'h0042 : 14'h0000);
         id = (k <= 2) ? 4'd6 : ((k <= 18) ? 4'd1 : 4'd0);
         applyStimulus("back_to_back", packExp(s, id, ((k >= 1 && k <= 8) || (k >= 10 && k <= 17)) ? 1'b0 : 1'b1));
         e = sbQ.pop_front();
         checks++;
         if (obs !== e.exp) begin
            errors++;
            $display("[TB] FAIL %s k=%0d got sts=%h req=%b id=%0d int_n=%b want sts=%h req=%b id=%0d int_n=%b",
                     e.tag, k, obs[19:6], obs[5], obs[4:1], obs[0], e.exp[19:6], e.exp[5], e.exp[4:1], e.exp[0]);
         end
      end
      clrVld = 1'b0;
   endtask

   task automatic test_mask();
      expT e;
      logic [13:0] s;
      for (int k = 0; k <= 31; k++) begin
         th      = (k <= 19) ? 4'd3 : 4'd0;
         err     = (k <= 20) ? 14'h0080 : 14'h0000;
         errMask = ((k <= 19) || (k == 29)) ? 14'h0080 : 14'h0000;
         clrVld  = (k == 30);
         clrBits = clrVld ? 14'h0080 : 14'h0000;
         s = (k >= 20 && k <= 29) ? 14'h0080 : 14'h0000;
         applyStimulus("mask", packExp(s, (s != 0) ? 4'd7 : 4'd0, (k >= 21 && k <= 28) ? 1'b0 : 1'b1));
         e = sbQ.pop_front();
         checks++;
         if (obs !== e.exp) begin
            errors++;
            $display("[TB] FAIL %s k=%0d got sts=%h req=%b id=%0d int_n=%b want sts=%h req=%b id=%0d int_n=%b",
                     e.tag, k, obs[19:6], obs[5], obs[4:1], obs[0], e.exp[19:6], e.exp[5], e.exp[4:1], e.exp[0]);
         end
      end
      clrVld  = 1'b0;
      errMask = '0;
   endtask

   task automatic test_int_en();
      expT e;
      logic [13:0] s;
      th = 4'd0;
      for (int k = 0; k <= 11; k++) begin
         intEn   = (k == 5) || (k >= 9);
         err     = (k == 0) ? 14'h0400 : 14'h0000;
         clrVld  = (k == 10);
         clrBits = clrVld ? 14'h0400 : 14'h0000;
         s = (k <= 9) ? 14'h0400 : 14'h0000;
         applyStimulus("int_en", packExp(s, (s != 0) ? 4'd10 : 4'd0, (k == 5) ? 1'b0 : 1'b1));
         e = sbQ.pop_front();
         checks++;
         if (obs !== e.exp) begin
            errors++;
            $display("[TB] FAIL %s k=%0d got sts=%h req=%b id=%0d int_n=%b want sts=%h req=%b id=%0d int_n=%b",
                     e.tag, k, obs[19:6], obs[5], obs[4:1], obs[0], e.exp[19:6], e.exp[5], e.exp[4:1], e.exp[0]);
         end
      end
      clrVld = 1'b0;
      intEn  = 1'b1;
   endtask

   task automatic test_reset_mid_assert();
      expT e;
      logic [13:0] s;
      th = 4'd0;
      for (int k = 0; k <= 11; k++) begin
         err    = ((k == 0) || (k == 6)) ? 14'h0041 : 14'h0000;
         rstN   = (k != 3);
         sftRst = (k == 9);
         s = ((k <= 2) || (k >= 6 && k <= 8)) ? 14'h0041 : 14'h0000;
         applyStimulus("reset_mid_assert", packExp(s, 4'd0, ((k >= 1 && k <= 2) || (k >= 7 && k <= 8)) ? 1'b0 : 1'b1));
         e = sbQ.pop_front();
         checks++;
         if (obs !== e.exp) begin
            errors++;
            $display("[TB] FAIL %s k=%0d got sts=%h req=%b id=%0d int_n=%b want sts=%h req=%b id=%0d int_n=%b",
                     e.tag, k, obs[19:6], obs[5], obs[4:1], obs[0], e.exp[19:6], e.exp[5], e.exp[4:1], e.exp[0]);
         end
      end
      rstN   = 1'b1;
      sftRst = 1'b0;
   endtask

   // Bound the whole run so a stuck simulation still reports.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog expired before the summary");
      $fatal(1, "[TB] watchdog");
   end

   // Scenario sequence; every scenario leaves the DUT idle with status clear.
   initial begin
      rstN    = 1'b0;
      sftRst  = 1'b0;
      err     = '0;
      errMask = '0;
      th      = '0;
      clrVld  = 1'b0;
      clrBits = '0;
      intEn   = 1'b1;
      @(negedge clock);
      test_reset();
      test_basic_filter();
      test_filter_edges();
      test_priority();
      test_clear_collision();
      test_back_to_back();
      test_mask();
      test_int_en();
      test_reset_mid_assert();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/lv_fault_sched.md
Name: lv_fault_sched

Overview:
Fault scheduler for the low-voltage die. It collects the 14 raw error levels (one-wire, SPI, CRC watchdog, PWM, supply, and HV faults) and filters each one with a per-source persistence counter. Qualified faults are latched into sticky status bits. The block then presents a prioritised fault request/ID to lv_ctrl_fsm and generates a timed active-low interrupt, with re-trigger on newly reported faults and software clear.

Parameters:
ERR_NUM, 14, number of error sources; bit 0 is the highest priority.
FLT_CNT_W, 4, width of the per-source filter counter and of the threshold.
INT_W, 8, number of cycles o_int_n is held low per interrupt event (must be ≥1).
ID_W, $clog2(ERR_NUM), width of o_flt_id (4 at default).

Ports:
i_clk  in  1  system clock; the only clock.
i_rst_n  in  1  reset; synchronous, active-low.
i_sft_rst  in  1  software reset; synchronous; same effect as i_rst_n.
i_err  in  ERR_NUM  raw error levels; 1 = error present.
i_err_mask  in  ERR_NUM  1 = source ignored (filter held at 0, never latched).
i_flt_th  in  FLT_CNT_W  filter threshold in cycles, common to all sources.
i_clr_vld  in  1  status clear strobe, one cycle.
i_clr_bits  in  ERR_NUM  sticky bits to clear when i_clr_vld=1.
i_int_en  in  1  interrupt enable.
o_err_sts  out  ERR_NUM  sticky qualified-fault status.
o_flt_req  out  1  1 = at least one sticky status bit is set.
o_flt_id  out  ID_W  index of the lowest set o_err_sts bit; 0 when o_flt_req=0.
o_int_n  out  1  interrupt, active-low.

Behaviour:
- Reset (i_rst_n=0 or i_sft_rst=1 at a clock edge) applies next cycle: all filter counters = 0, o_err_sts = 0, reported mask = 0, FSM = IDLE, o_flt_req = 0, o_flt_id = 0, o_int_n = 1. Reset during an active interrupt ends it immediately.
- Filter, per bit n, each cycle:
  - If i_err[n]=0 or i_err_mask[n]=1, cnt[n] ← 0.
  - Otherwise cnt[n] ← cnt[n]+1, saturating at 2^FLT_CNT_W−1.
  - qual[n] = i_err[n] & ~i_err_mask[n] & (cnt[n] ≥ i_flt_th).
  - With i_flt_th=0, a source qualifies in the first cycle it is high.
  - With i_flt_th=T, the source must be high for T+1 consecutive cycles. The sticky bit sets at the edge ending the (T+1)th cycle.
  - A single-cycle drop restarts the count.
- Sticky status, per bit: sts[n] ← qual[n] | (sts[n] & ~(i_clr_vld & i_clr_bits[n])). Set wins over a simultaneous clear. Masking a source does not clear an already latched bit.
- o_flt_req and o_flt_id are registered from the next-state sts, so they update in the same cycle as o_err_sts. Priority is a fixed lowest-index-first encoder.
- reported[n] tracks faults already signalled by an interrupt.
  - It clears together with sts[n].
  - new_flt = |(sts & ~reported).
- Interrupt FSM:
  - IDLE → ASSERT when new_flt & i_int_en.
  - ASSERT: o_int_n=0 and the hold counter runs for exactly INT_W cycles. On entry, reported ← reported | sts.
  - ASSERT → WAIT after INT_W cycles.
  - WAIT → ASSERT on new_flt & i_int_en. This needs at least 1 cycle of o_int_n=1 between pulses.
  - WAIT → IDLE when sts=0.
  - New faults arriving during ASSERT do not extend the pulse. They are added to reported only at the next ASSERT entry, so they trigger a re-assert from WAIT.
  - Deasserting i_int_en in ASSERT forces o_int_n=1 and goes to WAIT.
  - With i_int_en=0, faults latch and o_flt_req works, but there is no interrupt. Unreported faults assert an interrupt when i_int_en rises.
- o_int_n is registered and glitch-free; it equals 1 in every state except ASSERT.

Test Plan:
1. th=3, i_err[5] high for 4 cycles → o_err_sts=0x0020 on the 4th edge, o_flt_req=1, o_flt_id=5, o_int_n low for exactly 8 cycles. With the high time cut to 3 cycles → no latch.
2. Bits 9 and 2 qualify in the same cycle → o_flt_id=2. Clear bit 2 → o_flt_id=9 next cycle. Clear bit 9 → o_flt_req=0, o_flt_id=0, FSM returns to IDLE.
3. i_clr_vld with i_clr_bits[4]=1 in the same cycle bit 4 qualifies → o_err_sts[4] stays 1.
4. Bit 1 faults during ASSERT (cycle 3 of 8) → the pulse still ends after 8 cycles, o_int_n=1 for 1 cycle, then a second 8-cycle pulse.
5. i_err_mask[7]=1 with i_err[7] held high 20 cycles → o_err_sts[7]=0, no interrupt. Unmask with th=0 → latches next edge.
6. i_rst_n=0 for one edge mid-ASSERT with sts=0x0041 → next cycle all outputs 0, o_int_n=1. Repeat with i_sft_rst=1 → same result.
